id_ex_pipe_reg: RTL and testbench

//  Elastic ID/EX pipeline register for the MIPS core: captures decode payload (PC+4, register

---
 rtl/mips_pipe_pkg.sv | 52 +++++
 rtl/pipe_slot_reg.sv | 30 +++
 rtl/id_ex_pipe_reg.sv | 152 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared widths, control-word layout and ID/EX payload type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int c_XLEN   = 32;
    localparam int c_REG_AW = 5;
    localparam int CTRL_W   = 10;

    // Control word: {RegDst,Branch,MemRead,MemToReg,ALUop[2:0],MemWrite,ALUSrc,RegWrite}
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_BRANCH   = 8;
    localparam int CTRL_REGDST   = 9;

    localparam logic [2:0] c_ALUOP_ADD   = 3'd0;
    localparam logic [2:0] c_ALUOP_SUB   = 3'd1;
    localparam logic [2:0] c_ALUOP_AND   = 3'd2;
    localparam logic [2:0] c_ALUOP_OR    = 3'd3;
    localparam logic [2:0] c_ALUOP_SLT   = 3'd4;
    localparam logic [2:0] c_ALUOP_RTYPE = 3'd7;

    typedef struct packed {
        logic [c_XLEN-1:0]   pc4;
        logic [c_XLEN-1:0]   rd1;
        logic [c_XLEN-1:0]   rd2;
        logic [c_XLEN-1:0]   imm;
        logic [c_REG_AW-1:0] rt;
        logic [c_REG_AW-1:0] rd;
        logic [CTRL_W-1:0]   ctrl;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot_reg
// Description : One ID/EX payload register with load enable and async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot_reg
    import mips_pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  id_ex_payload_t i_d,
    output id_ex_payload_t o_q
);

    id_ex_payload_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : Elastic ID/EX register (2-entry skid), flush, bubble gating
//               and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN   = mips_pipe_pkg::c_XLEN,
    parameter int REG_AW = mips_pipe_pkg::c_REG_AW,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [XLEN-1:0]   in_rd1,
    input  logic [XLEN-1:0]   in_rd2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc4,
    output logic [XLEN-1:0]   out_rd1,
    output logic [XLEN-1:0]   out_rd2,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              load_use_haz
);

    import mips_pipe_pkg::*;

    pipe_state_e    r_state;
    logic           r_inReady;
    logic           w_inFire;
    logic           w_outFire;
    logic           w_mainLoad;
    logic           w_skidLoad;
    logic           w_mainFromSkid;
    id_ex_payload_t w_inPayload;
    id_ex_payload_t w_mainD;
    id_ex_payload_t w_mainQ;
    id_ex_payload_t w_skidQ;

    assign in_ready  = r_inReady;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_inFire  = in_valid & r_inReady;
    assign w_outFire = out_valid & out_ready;

    always_comb begin
        w_inPayload      = '0;
        w_inPayload.pc4  = in_pc4;
        w_inPayload.rd1  = in_rd1;
        w_inPayload.rd2  = in_rd2;
        w_inPayload.imm  = in_imm;
        w_inPayload.rt   = in_rt;
        w_inPayload.rd   = in_rd;
        w_inPayload.ctrl = in_ctrl;
    end

    // Slot load enables; a flush may still load but the data is never exposed.
    always_comb begin
        w_mainLoad     = 1'b0;
        w_skidLoad     = 1'b0;
        w_mainFromSkid = 1'b0;
        case (r_state)
            ST_EMPTY: w_mainLoad = w_inFire;
            ST_ONE: begin
                w_mainLoad = w_inFire & w_outFire;
                w_skidLoad = w_inFire & ~w_outFire;
            end
            ST_FULL: begin
                w_mainLoad     = w_outFire;
                w_mainFromSkid = 1'b1;
            end
            default: w_mainLoad = 1'b0;
        endcase
    end

    assign w_mainD = w_mainFromSkid ? w_skidQ : w_inPayload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_inReady <= 1'b1;
        end else if (flush) begin
            r_state   <= ST_EMPTY;
            r_inReady <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inFire) r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_inFire && !w_outFire) begin
                        r_state   <= ST_FULL;
                        r_inReady <= 1'b0;
                    end else if (!w_inFire && w_outFire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_outFire) begin
                        r_state   <= ST_ONE;
                        r_inReady <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_inReady <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot_reg u_mainSlot (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_mainLoad),
        .i_d    (w_mainD),
        .o_q    (w_mainQ)
    );

    pipe_slot_reg u_skidSlot (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skidLoad),
        .i_d    (w_inPayload),
        .o_q    (w_skidQ)
    );

    assign out_pc4  = w_mainQ.pc4;
    assign out_rd1  = w_mainQ.rd1;
    assign out_rd2  = w_mainQ.rd2;
    assign out_imm  = w_mainQ.imm;
    assign out_rt   = w_mainQ.rt;
    assign out_rd   = w_mainQ.rd;
    // Bubbles carry no control so nothing downstream writes or branches.
    assign out_ctrl = out_valid ? w_mainQ.ctrl : '0;

    assign load_use_haz = out_valid & is_load(w_mainQ.ctrl) & (w_mainQ.rt != '0)
                        & ((w_mainQ.rt == in_rs) | (w_mainQ.rt == in_rt));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Scoreboard bench for id_ex_pipe_reg with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;
    import mips_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, load_use_haz;
    logic [31:0] in_pc4, in_rd1, in_rd2, in_imm, out_pc4, out_rd1, out_rd2, out_imm;
    logic [4:0]  in_rs, in_rt, in_rd, out_rt, out_rd;
    logic [9:0]  in_ctrl, out_ctrl;

    int checks = 0;
    int errors = 0;
    id_ex_payload_t expQ[$];

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .load_use_haz(load_use_haz)
    );

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic id_ex_payload_t mk(input logic [31:0] pc4, input logic [4:0] rt,
                                          input logic [9:0] ctrl);
        id_ex_payload_t p;
        p.pc4 = pc4; p.rd1 = $urandom; p.rd2 = $urandom; p.imm = $urandom;
        p.rt = rt; p.rd = 5'($urandom_range(0, 31)); p.ctrl = ctrl;
        return p;
    endfunction

    // One cycle of stimulus; the model accepts when the handshake completes.
    task automatic step(input bit v, input id_ex_payload_t p, input logic [4:0] rs,
                        input bit ordy, input bit fl, output bit acc);
        @(negedge clk);
        in_valid = v; out_ready = ordy; flush = fl; in_rs = rs;
        in_pc4 = p.pc4; in_rd1 = p.rd1; in_rd2 = p.rd2; in_imm = p.imm;
        in_rt = p.rt; in_rd = p.rd; in_ctrl = p.ctrl;
        #4;
        acc = rst_n && v && in_ready && !fl;
        if (acc) expQ.push_back(p);
    endtask

    task automatic offer(input id_ex_payload_t p, input bit ordy);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(1'b1, p, 5'd0, ordy, 1'b0, acc);
            n++;
        end
        if (!acc) check("offer_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, mk(32'h0, 5'd0, 10'd0), 5'd0, ordy, 1'b0, acc);
    endtask

    // Monitor: expected occupancy is the scoreboard depth; head is the expected payload.
    initial begin : monitor
        bit             expV;
        bit             expHaz;
        id_ex_payload_t f;
        id_ex_payload_t got;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                expQ.delete();
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_out_ctrl", out_ctrl, 0);
                check("rst_haz", load_use_haz, 0);
                check("rst_payload", {out_pc4, out_rd1, out_rd2, out_imm, out_rt, out_rd}, 0);
            end else begin
                expV = (expQ.size() > 0);
                check("out_valid", out_valid, expV);
                check("in_ready", in_ready, expQ.size() < 2);
                expHaz = 1'b0;
                if (!expV) begin
                    check("bubble_ctrl", out_ctrl, 0);
                end else begin
                    f = expQ[0];
                    got.pc4 = out_pc4; got.rd1 = out_rd1; got.rd2 = out_rd2; got.imm = out_imm;
                    got.rt = out_rt; got.rd = out_rd; got.ctrl = out_ctrl;
                    check("payload", got, f);
                    expHaz = f.ctrl[CTRL_MEMREAD] && f.rt != 5'd0 && (f.rt == in_rs || f.rt == in_rt);
                end
                check("load_use_haz", load_use_haz, expHaz);
                if (flush) expQ.delete();
                else if (expV && out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin : stimulus
        bit acc;
        id_ex_payload_t p;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc4 = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_ctrl = '0;
        idle(2, 1'b0);
        rst_n = 1'b1;

        // Bubble: all-ones control on the port without valid
        for (int i = 0; i < 3; i++) begin
            step(1'b0, mk(32'h40, 5'd3, 10'h3FF), 5'd3, 1'b1, 1'b0, acc);
            check("bubble_out_ctrl", out_ctrl, 0);
        end

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, mk(32'(4 * i), 5'd1, 10'h001), 5'd0, 1'b1, 1'b0, acc);
            check("stream_acc", acc, 1);
        end
        idle(3, 1'b1);

        // Backpressure: 4 and 8 accepted, 12 held upstream until drain
        step(1'b1, mk(32'd4, 5'd2, 10'h001), 5'd0, 1'b0, 1'b0, acc);
        check("bp_acc4", acc, 1);
        step(1'b1, mk(32'd8, 5'd2, 10'h001), 5'd0, 1'b0, 1'b0, acc);
        check("bp_acc8", acc, 1);
        p = mk(32'd12, 5'd2, 10'h001);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, p, 5'd0, 1'b0, 1'b0, acc);
            check("bp_hold12", acc, 0);
        end
        offer(p, 1'b1);
        idle(4, 1'b1);

        // Flush while full with a same-cycle input
        offer(mk(32'h100, 5'd4, 10'h3FF), 1'b0);
        offer(mk(32'h104, 5'd4, 10'h3FF), 1'b0);
        step(1'b1, mk(32'h108, 5'd4, 10'h3FF), 5'd0, 1'b0, 1'b1, acc);
        #2;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_in_ready", in_ready, 1);
        idle(3, 1'b1);

        // Load-use hazard cases
        offer(mk(32'h200, 5'd5, 10'h080), 1'b0);
        step(1'b0, mk(32'h0, 5'd0, 10'h0), 5'd5, 1'b0, 1'b0, acc);
        check("haz_rs", load_use_haz, 1);
        step(1'b0, mk(32'h0, 5'd5, 10'h0), 5'd0, 1'b0, 1'b0, acc);
        check("haz_rt", load_use_haz, 1);
        step(1'b0, mk(32'h0, 5'd9, 10'h0), 5'd9, 1'b0, 1'b0, acc);
        check("haz_nomatch", load_use_haz, 0);
        idle(2, 1'b1);
        offer(mk(32'h204, 5'd0, 10'h080), 1'b0);
        step(1'b0, mk(32'h0, 5'd0, 10'h0), 5'd0, 1'b0, 1'b0, acc);
        check("haz_r0", load_use_haz, 0);
        idle(2, 1'b1);
        offer(mk(32'h208, 5'd5, 10'h37F), 1'b0);
        step(1'b0, mk(32'h0, 5'd5, 10'h0), 5'd5, 1'b0, 1'b0, acc);
        check("haz_noload", load_use_haz, 0);
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            p = mk($urandom, 5'($urandom_range(0, 7)), 10'($urandom));
            step($urandom_range(0, 3) != 0, p, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
        end

        // Mid-stream reset while full
        idle(3, 1'b1);
        offer(mk(32'h300, 5'd6, 10'h3FF), 1'b0);
        offer(mk(32'h304, 5'd6, 10'h3FF), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_ctrl", out_ctrl, 0);
        idle(1, 1'b0);
        rst_n = 1'b1;
        offer(mk(32'h400, 5'd1, 10'h001), 1'b1);
        idle(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
